ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- Execute stage plus EX/MEM pipeline register. It is the consumer end of the ID/EX register.
- Accepts the decoded fields latched by ID/EX and forwards operands from MEM and WB.
- Performs the ALU operation and computes the branch target and PC+4.
- Registers results and controls toward the memory stage, with stall, flush and valid handling.

Parameters:
- XLEN, 32, datapath width (operands, PC, results).
- FWD_EN, 1, 1 = forwarding muxes active; 0 = operands always taken from rd1_in/rd2_in.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold every output register
- flush  in  1  squash the instruction being latched this cycle
- valid_in  in  1  ID/EX slot holds a real instruction
- mem_write_in  in  1  store enable from ID/EX
- reg_write_in  in  1  register write enable from ID/EX
- alu_src_in  in  1  0 = operand B is forwarded rs2; 1 = imm_in
- mem_to_reg_in  in  2  writeback select, passed through
- alu_control_in  in  5  ALU opcode
- rs1_in, rs2_in, rd_in  in  5 each  register indices
- pc_in  in  XLEN  instruction PC
- rd1_in, rd2_in, imm_in  in  XLEN each  register-file data and sign-extended immediate
- mem_reg_write, wb_reg_write  in  1 each  write enables of the MEM and WB instructions
- mem_rd, wb_rd  in  5 each  destinations of the MEM and WB instructions
- mem_fwd_data, wb_fwd_data  in  XLEN each  forwardable results
- valid_out  out  1  EX/MEM slot valid
- mem_write_out, reg_write_out  out  1 each  gated controls
- mem_to_reg_out  out  2  writeback select
- rd_out  out  5  destination index
- alu_result_out, store_data_out, branch_target_out, pc4_out  out  XLEN each  registered results
- zero_out  out  1  registered (alu result == 0)

Behaviour:
- Reset (async, any time, including mid-stall): every output = 0. The in-flight instruction is discarded.
- Forwarding (combinational, per operand, FWD_EN=1):
  - Source = mem_fwd_data if mem_reg_write && mem_rd != 0 && mem_rd == rsX_in.
  - Else wb_fwd_data if wb_reg_write && wb_rd != 0 && wb_rd == rsX_in.
  - Else rd1_in / rd2_in.
  - MEM has priority over WB. x0 is never forwarded.
- Operand A = forwarded rs1. Operand B = imm_in if alu_src_in, else forwarded rs2. store_data = forwarded rs2, regardless of alu_src_in.
- ALU opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU.
  - Shifts use B[4:0].
  - SLT/SLTU produce 1 or 0 zero-extended.
  - Opcodes 10-31 produce 0.
  - All arithmetic is modulo 2^XLEN; no overflow flag.
- branch_target = pc_in + imm_in. pc4 = pc_in + 4. Both wrap modulo 2^XLEN. (The adder lives here, not in ID/EX.)
- Latency: 1 cycle. Inputs present at edge N appear on the outputs after edge N.
- Register update at each rising edge, by priority:
  1. flush=1: valid_out, mem_write_out and reg_write_out clear to 0. Data fields may load but are don't-care.
  2. Else stall=1: all outputs hold their values.
  3. Else: load everything. mem_write_out = mem_write_in & valid_in. reg_write_out = reg_write_in & valid_in & (rd_in != 0). valid_out = valid_in.
- flush and stall asserted together: flush wins and the slot becomes a bubble.
- valid_in=0: a bubble is latched. mem_write_out and reg_write_out are 0 and data is don't-care.
- rd_in=0 with reg_write_in=1: reg_write_out=0, so x0 writes are suppressed here.
- Forwarding sources are sampled in the same cycle as the ALU. During stall, held outputs are not recomputed.

Test Plan:
- Reset/ADD: assert rst mid-run, then check all outputs = 0. Release rst and drive ADD with rd1=5, rd2=7, valid, rd=3, reg_write=1. Next cycle: alu_result_out=12, reg_write_out=1, rd_out=3, zero_out=0.
- Forward priority: rs1=4, mem_rd=4 with mem_fwd_data=0x100, wb_rd=4 with wb_fwd_data=0x200, rd2=1, ADD. Expect result 0x101. Repeat with mem_reg_write=0: expect 0x201. Repeat with rs1=0: expect rd1_in+1.
- Branch/immediate: pc_in=0xFFFFFFFC, imm_in=8, alu_src=1, SUB with rd1=8. Expect branch_target_out=0x4 (wrap), pc4_out=0x0, alu_result_out=0, zero_out=1.
- Stall/flush: load a valid SW (mem_write=1). Assert stall for 3 cycles while changing inputs: outputs hold. Then assert flush and stall together: valid_out=0, mem_write_out=0.
- Shifts/compare: rd1=0x80000000, B=4. SRA gives 0xF8000000, SRL gives 0x08000000. SLT with rd1=-1, rd2=1 gives 1. SLTU with the same operands gives 0. Opcode 31 gives 0.
- x0 suppression: reg_write_in=1, rd_in=0 -> reg_write_out=0. valid_in=0 with mem_write_in=1 -> mem_write_out=0, valid_out=0.

Source files
------------

// File: rtl/ex_mem_stage.sv
// Execute stage with EX/MEM pipeline register.
// Forwards operands, runs the ALU, computes branch target and PC+4.
module ex_mem_stage #(
   parameter int XLEN   = 32,
   parameter bit FWD_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            flush,
   input  logic            valid_in,
   input  logic            mem_write_in,
   input  logic            reg_write_in,
   input  logic            alu_src_in,
   input  logic [1:0]      mem_to_reg_in,
   input  logic [4:0]      alu_control_in,
   input  logic [4:0]      rs1_in,
   input  logic [4:0]      rs2_in,
   input  logic [4:0]      rd_in,
   input  logic [XLEN-1:0] pc_in,
   input  logic [XLEN-1:0] rd1_in,
   input  logic [XLEN-1:0] rd2_in,
   input  logic [XLEN-1:0] imm_in,
   input  logic            mem_reg_write,
   input  logic            wb_reg_write,
   input  logic [4:0]      mem_rd,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] mem_fwd_data,
   input  logic [XLEN-1:0] wb_fwd_data,
   output logic            valid_out,
   output logic            mem_write_out,
   output logic            reg_write_out,
   output logic [1:0]      mem_to_reg_out,
   output logic [4:0]      rd_out,
   output logic [XLEN-1:0] alu_result_out,
   output logic [XLEN-1:0] store_data_out,
   output logic [XLEN-1:0] branch_target_out,
   output logic [XLEN-1:0] pc4_out,
   output logic            zero_out
);

   logic [XLEN-1:0] fwd_a;
   logic [XLEN-1:0] fwd_b;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] alu_res;
   logic [4:0]      shamt;

   // Operand forwarding: MEM beats WB, x0 is never forwarded
   always_comb begin
      fwd_a = rd1_in;
      fwd_b = rd2_in;
      if (FWD_EN) begin
         if (mem_reg_write && mem_rd != 5'd0 && mem_rd == rs1_in)
            fwd_a = mem_fwd_data;
         else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs1_in)
            fwd_a = wb_fwd_data;
         if (mem_reg_write && mem_rd != 5'd0 && mem_rd == rs2_in)
            fwd_b = mem_fwd_data;
         else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs2_in)
            fwd_b = wb_fwd_data;
      end
   end

   assign op_b  = alu_src_in ? imm_in : fwd_b;
   assign shamt = op_b[4:0];

   // ALU; unassigned opcodes yield zero
   always_comb begin
      alu_res = '0;
      case (alu_control_in)
         5'd0: alu_res = fwd_a + op_b;
         5'd1: alu_res = fwd_a - op_b;
         5'd2: alu_res = fwd_a & op_b;
         5'd3: alu_res = fwd_a | op_b;
         5'd4: alu_res = fwd_a ^ op_b;
         5'd5: alu_res = fwd_a << shamt;
         5'd6: alu_res = fwd_a >> shamt;
         5'd7: alu_res = $signed(fwd_a) >>> shamt;
         5'd8: alu_res = {{(XLEN-1){1'b0}},
                          ($signed(fwd_a) < $signed(op_b))};
         5'd9: alu_res = {{(XLEN-1){1'b0}}, (fwd_a < op_b)};
         default: alu_res = '0;
      endcase
   end

   // EX/MEM register: flush beats stall, stall holds everything
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_out         <= 1'b0;
         mem_write_out     <= 1'b0;
         reg_write_out     <= 1'b0;
         mem_to_reg_out    <= '0;
         rd_out            <= '0;
         alu_result_out    <= '0;
         store_data_out    <= '0;
         branch_target_out <= '0;
         pc4_out           <= '0;
         zero_out          <= 1'b0;
      end else if (flush) begin
         valid_out     <= 1'b0;
         mem_write_out <= 1'b0;
         reg_write_out <= 1'b0;
      end else if (!stall) begin
         valid_out         <= valid_in;
         mem_write_out     <= mem_write_in & valid_in;
         reg_write_out     <= reg_write_in & valid_in & (rd_in != 5'd0);
         mem_to_reg_out    <= mem_to_reg_in;
         rd_out            <= rd_in;
         alu_result_out    <= alu_res;
         store_data_out    <= fwd_b;
         branch_target_out <= pc_in + imm_in;
         pc4_out           <= pc_in + XLEN'(4);
         zero_out          <= (alu_res == '0);
      end
   end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage with an expected-result queue.
// Each step pushes the expected register contents, then clocks and pops.
module tb_ex_mem_stage;

   typedef struct {
      logic        valid;
      logic        mw;
      logic        rw;
      logic [1:0]  m2r;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic [31:0] sd;
      logic [31:0] bt;
      logic [31:0] pc4;
      logic        zero;
      bit          ctrl_only;
      string       tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, flush, valid_in, mem_write_in, reg_write_in;
   logic        alu_src_in;
   logic [1:0]  mem_to_reg_in;
   logic [4:0]  alu_control_in, rs1_in, rs2_in, rd_in;
   logic [31:0] pc_in, rd1_in, rd2_in, imm_in;
   logic        mem_reg_write, wb_reg_write;
   logic [4:0]  mem_rd, wb_rd;
   logic [31:0] mem_fwd_data, wb_fwd_data;
   logic        valid_out, mem_write_out, reg_write_out, zero_out;
   logic [1:0]  mem_to_reg_out;
   logic [4:0]  rd_out;
   logic [31:0] alu_result_out, store_data_out;
   logic [31:0] branch_target_out, pc4_out;

   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   exp_t e_sw;

   ex_mem_stage #(.XLEN(32), .FWD_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .valid_in(valid_in), .mem_write_in(mem_write_in),
      .reg_write_in(reg_write_in), .alu_src_in(alu_src_in),
      .mem_to_reg_in(mem_to_reg_in), .alu_control_in(alu_control_in),
      .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in),
      .pc_in(pc_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
      .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
      .mem_rd(mem_rd), .wb_rd(wb_rd),
      .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
      .valid_out(valid_out), .mem_write_out(mem_write_out),
      .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
      .rd_out(rd_out), .alu_result_out(alu_result_out),
      .store_data_out(store_data_out),
      .branch_target_out(branch_target_out),
      .pc4_out(pc4_out), .zero_out(zero_out)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic exp_t mk(input string tag, input logic v,
                               input logic mw, input logic rw,
                               input logic [1:0] m2r, input logic [4:0] rd,
                               input logic [31:0] alu, input logic [31:0] sd,
                               input logic [31:0] bt, input logic [31:0] pc4,
                               input logic z);
      exp_t e;
      e.tag = tag; e.valid = v; e.mw = mw; e.rw = rw; e.m2r = m2r;
      e.rd = rd; e.alu = alu; e.sd = sd; e.bt = bt; e.pc4 = pc4;
      e.zero = z; e.ctrl_only = 1'b0;
      return e;
   endfunction

   function automatic exp_t bubble(input string tag);
      exp_t e;
      e = mk(tag, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 0, 0, 0, 0, 1'b0);
      e.ctrl_only = 1'b1;
      return e;
   endfunction

   task automatic check_out();
      exp_t e;
      if (q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard observed=empty expected=entry");
      end else begin
         e = q.pop_front();
         chk({e.tag, ".valid"}, 32'(valid_out), 32'(e.valid));
         chk({e.tag, ".mw"}, 32'(mem_write_out), 32'(e.mw));
         chk({e.tag, ".rw"}, 32'(reg_write_out), 32'(e.rw));
         if (!e.ctrl_only) begin
            chk({e.tag, ".m2r"}, 32'(mem_to_reg_out), 32'(e.m2r));
            chk({e.tag, ".rd"}, 32'(rd_out), 32'(e.rd));
            chk({e.tag, ".alu"}, alu_result_out, e.alu);
            chk({e.tag, ".sd"}, store_data_out, e.sd);
            chk({e.tag, ".bt"}, branch_target_out, e.bt);
            chk({e.tag, ".pc4"}, pc4_out, e.pc4);
            chk({e.tag, ".zero"}, 32'(zero_out), 32'(e.zero));
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      check_out();
   endtask

   task automatic clr();
      stall = 0; flush = 0; valid_in = 0; mem_write_in = 0;
      reg_write_in = 0; alu_src_in = 0; mem_to_reg_in = 0;
      alu_control_in = 0; rs1_in = 0; rs2_in = 0; rd_in = 0;
      pc_in = 0; rd1_in = 0; rd2_in = 0; imm_in = 0;
      mem_reg_write = 0; wb_reg_write = 0; mem_rd = 0; wb_rd = 0;
      mem_fwd_data = 0; wb_fwd_data = 0;
   endtask

   task automatic alu_op(input string tag, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic src, input logic [31:0] res);
      clr();
      valid_in = 1; reg_write_in = 1; rd_in = 5'd9;
      alu_control_in = op; rd1_in = a; alu_src_in = src;
      if (src) begin
         imm_in = b; rd2_in = 32'h0;
      end else begin
         rd2_in = b;
      end
      q.push_back(mk(tag, 1, 0, 1, 2'd0, 5'd9, res, rd2_in,
                     imm_in, 32'd4, res == 0));
      tick();
   endtask

   initial begin
      clr();
      rst = 1;
      #3;
      q.push_back(mk("reset0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      check_out();
      @(negedge clk);
      rst = 0;

      // ADD 5 + 7
      clr();
      valid_in = 1; reg_write_in = 1; rd_in = 5'd3; mem_to_reg_in = 2'd1;
      rs1_in = 5'd1; rs2_in = 5'd2; rd1_in = 5; rd2_in = 7;
      pc_in = 32'h100;
      q.push_back(mk("add", 1, 0, 1, 2'd1, 5'd3, 32'd12, 32'd7,
                     32'h100, 32'h104, 0));
      tick();

      // async reset in the middle of a stall, no clock edge
      stall = 1;
      #2;
      rst = 1;
      #1;
      q.push_back(mk("reset_mid", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      check_out();
      @(negedge clk);
      rst = 0;

      // forwarding priority
      clr();
      valid_in = 1; reg_write_in = 1; rd_in = 5'd6;
      rs1_in = 5'd4; rs2_in = 5'd5; rd1_in = 32'h55; rd2_in = 32'h1;
      mem_reg_write = 1; mem_rd = 5'd4; mem_fwd_data = 32'h100;
      wb_reg_write = 1; wb_rd = 5'd4; wb_fwd_data = 32'h200;
      q.push_back(mk("fwd_mem", 1, 0, 1, 0, 5'd6, 32'h101, 32'h1,
                     0, 4, 0));
      tick();
      mem_reg_write = 0;
      q.push_back(mk("fwd_wb", 1, 0, 1, 0, 5'd6, 32'h201, 32'h1,
                     0, 4, 0));
      tick();
      rs1_in = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0; mem_reg_write = 1;
      q.push_back(mk("fwd_x0", 1, 0, 1, 0, 5'd6, 32'h56, 32'h1,
                     0, 4, 0));
      tick();

      // rs2 forwarded into store data while B is the immediate
      clr();
      valid_in = 1; reg_write_in = 1; rd_in = 5'd8; alu_src_in = 1;
      rs2_in = 5'd7; rd2_in = 32'h99; rd1_in = 32'h1; imm_in = 32'h10;
      wb_reg_write = 1; wb_rd = 5'd7; wb_fwd_data = 32'h33;
      pc_in = 32'h40;
      q.push_back(mk("fwd_sd", 1, 0, 1, 0, 5'd8, 32'h11, 32'h33,
                     32'h50, 32'h44, 0));
      tick();

      // branch target and pc4 wrap, SUB to zero
      clr();
      valid_in = 1; pc_in = 32'hFFFF_FFFC; imm_in = 32'd8;
      alu_src_in = 1; alu_control_in = 5'd1; rd1_in = 32'd8;
      rd2_in = 32'h9; rd_in = 5'd2;
      q.push_back(mk("branch", 1, 0, 0, 0, 5'd2, 32'h0, 32'h9,
                     32'h4, 32'h0, 1));
      tick();

      // store, then 3 stalled cycles with changing inputs
      clr();
      valid_in = 1; mem_write_in = 1; alu_src_in = 1;
      rd1_in = 32'h1000; imm_in = 32'd4; rd2_in = 32'hAB;
      mem_to_reg_in = 2'd2;
      e_sw = mk("sw", 1, 1, 0, 2'd2, 5'd0, 32'h1004, 32'hAB,
                32'h4, 32'h4, 0);
      q.push_back(e_sw);
      tick();
      for (int i = 0; i < 3; i++) begin
         stall = 1; valid_in = 0; reg_write_in = 1; rd_in = 5'(i + 1);
         rd1_in = 32'(i * 77); pc_in = 32'(i * 16); mem_write_in = 0;
         e_sw.tag = "stall";
         q.push_back(e_sw);
         tick();
      end
      flush = 1; stall = 1; valid_in = 1; mem_write_in = 1;
      q.push_back(bubble("flush_stall"));
      tick();

      // logic, shifts and compares
      alu_op("and", 5'd2, 32'hF0F0, 32'hFF00, 0, 32'hF000);
      alu_op("or", 5'd3, 32'hF0F0, 32'hFF00, 0, 32'hFFF0);
      alu_op("xor", 5'd4, 32'hF0F0, 32'hFF00, 0, 32'h0FF0);
      alu_op("sll", 5'd5, 32'h8000_0001, 32'd4, 1, 32'h0000_0010);
      alu_op("sra", 5'd7, 32'h8000_0000, 32'd4, 1, 32'hF800_0000);
      alu_op("srl", 5'd6, 32'h8000_0000, 32'd4, 1, 32'h0800_0000);
      alu_op("srl_b40", 5'd6, 32'h8000_0000, 32'h24, 1, 32'h0800_0000);
      alu_op("slt", 5'd8, 32'hFFFF_FFFF, 32'd1, 0, 32'd1);
      alu_op("sltu", 5'd9, 32'hFFFF_FFFF, 32'd1, 0, 32'd0);
      alu_op("op31", 5'd31, 32'h1234, 32'h5678, 0, 32'd0);

      // x0 write suppression and bubble
      clr();
      valid_in = 1; reg_write_in = 1; rd_in = 5'd0; rd1_in = 32'd3;
      q.push_back(mk("x0", 1, 0, 0, 0, 5'd0, 32'd3, 32'd0,
                     0, 4, 0));
      tick();
      clr();
      valid_in = 0; mem_write_in = 1; reg_write_in = 1; rd_in = 5'd4;
      q.push_back(bubble("bubble"));
      tick();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
